spiking_array_feeder_2x2: RTL and testbench

//  Transmit side of the 2x2 spiking systolic array's FIFO interface. Accepts a

---
 rtl/spiking_array_feeder_2x2_pkg.sv | 16 +
 rtl/spiking_array_feeder_2x2_skew_shift.sv | 28 ++
 rtl/spiking_array_feeder_2x2.sv | 140 ++++++++++++++
 tb/tb_spiking_array_feeder_2x2.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiking_array_feeder_2x2_pkg.sv
// Shared definitions for the 2x2 spiking array feeder: FSM state encoding and
// the width helper used for the step/flush counters.
package spiking_array_feeder_2x2_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } feeder_state_t;

   // Counters must hold the full range 0..limit inclusive.
   function automatic int count_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/spiking_array_feeder_2x2_skew_shift.sv
// N-lane enable skew: lane k is the input enable delayed by k cycles, so a
// single "step t" strobe becomes the diagonal read pattern of an NxN array.
module spiking_array_feeder_2x2_skew_shift
   import spiking_array_feeder_2x2_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en_in,
   output logic [N-1:0] en_out
);

   logic [N-1:1] dly;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dly <= '0;
      end else begin
         for (int k = 1; k < N; k++) begin
            dly[k] <= en_out[k-1];
         end
      end
   end

   assign en_out = {dly, en_in};

endmodule

// File: rtl/spiking_array_feeder_2x2.sv
// Transmit side of the 2x2 spiking systolic array: loads K steps into the row
// and column FIFOs, replays them with a diagonal read skew, then pulses done.
module spiking_array_feeder_2x2
   import spiking_array_feeder_2x2_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [1:0]              s_spikes,
   input  logic [2*DATA_WIDTH-1:0] s_weights,
   input  logic                    s_last,
   output logic                    in_row_0,
   output logic                    in_row_1,
   output logic                    row_fifo_0_w_en,
   output logic                    row_fifo_1_w_en,
   output logic                    row_fifo_0_r_en,
   output logic                    row_fifo_1_r_en,
   output logic [DATA_WIDTH-1:0]   in_col_0,
   output logic [DATA_WIDTH-1:0]   in_col_1,
   output logic                    col_fifo_0_w_en,
   output logic                    col_fifo_1_w_en,
   output logic                    col_fifo_0_r_en,
   output logic                    col_fifo_1_r_en,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              dbg_state
);

   localparam int CW = count_width(DEPTH);
   localparam int FW = count_width(FLUSH_CYCLES);
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_SLOT  = CW'(DEPTH - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   feeder_state_t state, state_nxt;

   logic [CW-1:0]         count;
   logic [CW-1:0]         t_cnt;
   logic [FW-1:0]         f_cnt;
   logic                  closed;
   logic                  hs;
   logic                  close_batch;
   logic                  flush_end;
   logic                  lane0;
   logic [1:0]            r_en;
   logic                  w_en_q;
   logic [1:0]            row_q;
   logic [DATA_WIDTH-1:0] col0_q;
   logic [DATA_WIDTH-1:0] col1_q;
   logic                  done_q;

   // Handshake: a step transfers on a cycle where s_valid and s_ready are both
   // high. s_ready never depends on s_valid; a valid step offered while s_ready
   // is low is simply not taken and is not held off by any stall.
   always_comb begin
      s_ready     = 1'b0;
      hs          = 1'b0;
      close_batch = 1'b0;
      flush_end   = 1'b0;
      lane0       = 1'b0;
      state_nxt   = state;

      s_ready     = (state == ST_LOAD) && !closed && (count < DEPTH_C);
      hs          = s_valid && s_ready;
      close_batch = hs && (s_last || (count == LAST_SLOT));
      flush_end   = (state == ST_FLUSH) && (f_cnt == FLUSH_LAST);
      lane0       = (state == ST_DRAIN) && (t_cnt < count);

      // The closed LOAD cycle lets the last write land before reads begin.
      case (state)
         ST_LOAD:  if (closed)           state_nxt = ST_DRAIN;
         ST_DRAIN: if (t_cnt == count)   state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush_end)        state_nxt = ST_LOAD;
         default:                        state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= ST_LOAD;
         count  <= '0;
         t_cnt  <= '0;
         f_cnt  <= '0;
         closed <= 1'b0;
         w_en_q <= 1'b0;
         row_q  <= '0;
         col0_q <= '0;
         col1_q <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         w_en_q <= hs;
         done_q <= flush_end;
         if (hs) begin
            row_q  <= s_spikes;
            col0_q <= s_weights[DATA_WIDTH-1:0];
            col1_q <= s_weights[2*DATA_WIDTH-1:DATA_WIDTH];
            count  <= count + 1'b1;
         end
         if (close_batch) begin
            closed <= 1'b1;
         end
         t_cnt <= (state == ST_DRAIN) ? t_cnt + 1'b1 : '0;
         f_cnt <= (state == ST_FLUSH) ? f_cnt + 1'b1 : '0;
         if (flush_end) begin
            count  <= '0;
            closed <= 1'b0;
         end
      end
   end

   spiking_array_feeder_2x2_skew_shift #(.N(2)) u_skew (
      .clk    (clk),
      .rstn   (rstn),
      .en_in  (lane0),
      .en_out (r_en)
   );

   assign in_row_0        = row_q[0];
   assign in_row_1        = row_q[1];
   assign in_col_0        = col0_q;
   assign in_col_1        = col1_q;
   assign row_fifo_0_w_en = w_en_q;
   assign row_fifo_1_w_en = w_en_q;
   assign col_fifo_0_w_en = w_en_q;
   assign col_fifo_1_w_en = w_en_q;
   assign row_fifo_0_r_en = r_en[0];
   assign col_fifo_0_r_en = r_en[0];
   assign row_fifo_1_r_en = r_en[1];
   assign col_fifo_1_r_en = r_en[1];
   assign busy            = (state == ST_DRAIN) || (state == ST_FLUSH);
   assign done            = done_q;
   assign dbg_state       = state;

endmodule

// File: tb/tb_spiking_array_feeder_2x2.sv
// Bench for spiking_array_feeder_2x2: timeline model of the feeder plus an
// emulated 2x2 array (FIFOs + skewed PEs) whose sums are scored at done.
module tb_spiking_array_feeder_2x2;

   localparam int DEPTH = 8;
   localparam int DW    = 16;
   localparam int FC    = 4;
   localparam int MAXC  = 1024;

   logic          clk = 1'b0;
   logic          rstn;
   logic          s_valid;
   logic          s_ready;
   logic [1:0]    s_spikes;
   logic [2*DW-1:0] s_weights;
   logic          s_last;
   logic          in_row_0, in_row_1;
   logic          row_fifo_0_w_en, row_fifo_1_w_en, row_fifo_0_r_en, row_fifo_1_r_en;
   logic [DW-1:0] in_col_0, in_col_1;
   logic          col_fifo_0_w_en, col_fifo_1_w_en, col_fifo_0_r_en, col_fifo_1_r_en;
   logic          busy, done;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   spiking_array_feeder_2x2 #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
      .s_spikes(s_spikes), .s_weights(s_weights), .s_last(s_last),
      .in_row_0(in_row_0), .in_row_1(in_row_1),
      .row_fifo_0_w_en(row_fifo_0_w_en), .row_fifo_1_w_en(row_fifo_1_w_en),
      .row_fifo_0_r_en(row_fifo_0_r_en), .row_fifo_1_r_en(row_fifo_1_r_en),
      .in_col_0(in_col_0), .in_col_1(in_col_1),
      .col_fifo_0_w_en(col_fifo_0_w_en), .col_fifo_1_w_en(col_fifo_1_w_en),
      .col_fifo_0_r_en(col_fifo_0_r_en), .col_fifo_1_r_en(col_fifo_1_r_en),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // ---------------- clock/cycle bookkeeping ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, $signed(act), $signed(exp));
      end
   endtask

   // ---------------- timeline model ----------------
   logic e_wen [MAXC];
   logic e_r0  [MAXC];
   logic e_r1  [MAXC];
   logic e_busy[MAXC];
   logic e_done[MAXC];
   int   free_from;
   int   mcount;
   int   bsum [2][2];
   logic [1:0]    cur_row, pend_row;
   logic [DW-1:0] cur_c0, cur_c1, pend_c0, pend_c1;
   logic          pend_v;
   logic [31:0]   exp_q[$];

   // ---------------- emulated array ----------------
   logic          rq0[$], rq1[$];
   logic [DW-1:0] cq0[$], cq1[$];
   logic          rh_v[2][MAXC];
   logic          rh_d[2][MAXC];
   logic          ch_v[2][MAXC];
   logic [DW-1:0] ch_d[2][MAXC];
   int acc [2][2];
   int snap[2][2];
   int done_cnt = 0, last_done_cyc = 0, wen_cnt = 0, last_wen_cyc = 0, hs_cyc = 0;

   task automatic model_reset(input int c);
      for (int x = c + 1; x < MAXC; x++) begin
         e_wen[x] = 1'b0; e_r0[x] = 1'b0; e_r1[x] = 1'b0; e_busy[x] = 1'b0; e_done[x] = 1'b0;
      end
      free_from = c + 1;
      mcount    = 0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin bsum[i][j] = 0; acc[i][j] = 0; end
      pend_v = 1'b1; pend_row = '0; pend_c0 = '0; pend_c1 = '0;
      exp_q.delete();
      rq0.delete(); rq1.delete(); cq0.delete(); cq1.delete();
      for (int i = 0; i < 2; i++) begin rh_v[i][c] = 1'b0; ch_v[i][c] = 1'b0; end
   endtask

   task automatic model_accept(input int c, input logic [1:0] sp, input int w0, input int w1,
                               input logic last);
      int k;
      pend_v = 1'b1; pend_row = sp; pend_c0 = DW'(w0); pend_c1 = DW'(w1);
      e_wen[c+1] = 1'b1;
      mcount++;
      for (int i = 0; i < 2; i++) begin
         if (sp[i]) begin bsum[i][0] += w0; bsum[i][1] += w1; end
      end
      if (last || mcount == DEPTH) begin
         k = mcount;
         for (int t = 0; t < k; t++) begin e_r0[c+2+t] = 1'b1; e_r1[c+3+t] = 1'b1; end
         for (int x = c + 2; x <= c + k + 2 + FC; x++) e_busy[x] = 1'b1;
         e_done[c+k+3+FC] = 1'b1;
         free_from = c + k + 3 + FC;
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin exp_q.push_back(bsum[i][j]); bsum[i][j] = 0; end
         mcount = 0;
      end
   endtask

   task automatic emulate_array();
      logic rv, cv;
      if (row_fifo_0_w_en) begin
         rq0.push_back(in_row_0); rq1.push_back(in_row_1);
         cq0.push_back(in_col_0); cq1.push_back(in_col_1);
         wen_cnt++; last_wen_cyc = cyc;
      end
      rh_v[0][cyc] = 1'b0; rh_v[1][cyc] = 1'b0; ch_v[0][cyc] = 1'b0; ch_v[1][cyc] = 1'b0;
      if (row_fifo_0_r_en) begin
         chk("row0_pop_nonempty", rq0.size() != 0, 1'b1);
         if (rq0.size() != 0) begin rh_v[0][cyc] = 1'b1; rh_d[0][cyc] = rq0.pop_front(); end
      end
      if (row_fifo_1_r_en) begin
         chk("row1_pop_nonempty", rq1.size() != 0, 1'b1);
         if (rq1.size() != 0) begin rh_v[1][cyc] = 1'b1; rh_d[1][cyc] = rq1.pop_front(); end
      end
      if (col_fifo_0_r_en) begin
         chk("col0_pop_nonempty", cq0.size() != 0, 1'b1);
         if (cq0.size() != 0) begin ch_v[0][cyc] = 1'b1; ch_d[0][cyc] = cq0.pop_front(); end
      end
      if (col_fifo_1_r_en) begin
         chk("col1_pop_nonempty", cq1.size() != 0, 1'b1);
         if (cq1.size() != 0) begin ch_v[1][cyc] = 1'b1; ch_d[1][cyc] = cq1.pop_front(); end
      end
      // PE(i,j) sees row i shifted j places and column j shifted i places.
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            if (cyc >= i && cyc >= j) begin
               rv = rh_v[i][cyc-j];
               cv = ch_v[j][cyc-i];
               if (rv || cv) chk($sformatf("pe%0d%0d_align", i, j), rv, cv);
               if (rv && cv && rh_d[i][cyc-j]) acc[i][j] += int'($signed(ch_d[j][cyc-i]));
            end
         end
      end
      if (done) begin
         done_cnt++; last_done_cyc = cyc;
         chk("fifos_drained", rq0.size() + rq1.size() + cq0.size() + cq1.size(), 0);
         chk("batch_scored", exp_q.size() >= 4, 1'b1);
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               if (exp_q.size() != 0) chk($sformatf("out_data_%0d_%0d", i, j), acc[i][j], exp_q.pop_front());
               snap[i][j] = acc[i][j];
               acc[i][j]  = 0;
            end
      end
   endtask

   // Per-cycle compare against the timeline model, then advance the model.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC - 32) begin
         if (pend_v) begin
            cur_row = pend_row; cur_c0 = pend_c0; cur_c1 = pend_c1; pend_v = 1'b0;
         end
         chk("s_ready",    s_ready,         cyc >= free_from);
         chk("row0_w_en",  row_fifo_0_w_en, e_wen[cyc]);
         chk("row1_w_en",  row_fifo_1_w_en, e_wen[cyc]);
         chk("col0_w_en",  col_fifo_0_w_en, e_wen[cyc]);
         chk("col1_w_en",  col_fifo_1_w_en, e_wen[cyc]);
         chk("row0_r_en",  row_fifo_0_r_en, e_r0[cyc]);
         chk("col0_r_en",  col_fifo_0_r_en, e_r0[cyc]);
         chk("row1_r_en",  row_fifo_1_r_en, e_r1[cyc]);
         chk("col1_r_en",  col_fifo_1_r_en, e_r1[cyc]);
         chk("busy",       busy,            e_busy[cyc]);
         chk("done",       done,            e_done[cyc]);
         chk("in_row_0",   in_row_0,        cur_row[0]);
         chk("in_row_1",   in_row_1,        cur_row[1]);
         chk("in_col_0",   in_col_0,        cur_c0);
         chk("in_col_1",   in_col_1,        cur_c1);
         emulate_array();
         if (!rstn) model_reset(cyc);
         else if (s_valid && cyc >= free_from)
            model_accept(cyc, s_spikes, int'($signed(s_weights[DW-1:0])),
                         int'($signed(s_weights[2*DW-1:DW])), s_last);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [1:0] sp, input int w0, input int w1,
                        input logic l);
      s_valid = v; s_spikes = sp; s_weights = {DW'(w1), DW'(w0)}; s_last = l;
      hs_cyc = cyc;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 2'b00, 0, 0, 1'b0);
   endtask

   task automatic wait_done(input int budget, output int dc);
      int start;
      start = done_cnt;
      for (int k = 0; k < budget && done_cnt == start; k++) @(posedge clk);
      #1;
      chk("done_within_budget", done_cnt != start, 1'b1);
      dc = last_done_cyc;
   endtask

   task automatic chk_snap(input string tag, input int a00, input int a01, input int a10,
                           input int a11);
      chk({tag, "_out00"}, snap[0][0], a00);
      chk({tag, "_out01"}, snap[0][1], a01);
      chk({tag, "_out10"}, snap[1][0], a10);
      chk({tag, "_out11"}, snap[1][1], a11);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, dc, d1;
      rstn = 1'b0; s_valid = 1'b0; s_spikes = '0; s_weights = '0; s_last = 1'b0;
      for (int i = 0; i < 2; i++) begin rh_v[i][0] = 1'b0; ch_v[i][0] = 1'b0; end
      model_reset(0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      chk("reset_s_ready", s_ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      idle(1);

      // K=3 with s_last on beat 3; also the end-to-end array sums.
      wen_cnt = 0;
      drive(1'b1, 2'b01, 2, -1, 1'b0);
      drive(1'b1, 2'b11, 3,  5, 1'b0);
      drive(1'b1, 2'b10, 4,  7, 1'b1);
      n = hs_cyc;
      s_valid = 1'b0;
      wait_done(40, dc);
      chk("t1_done_latency", dc - n, 10);
      chk("t1_writes", wen_cnt, 3);
      chk_snap("t1", 5, 4, 7, 12);
      idle(2);

      // Eight beats without s_last: auto-close, 9th offer refused.
      wen_cnt = 0;
      for (int i = 0; i < 8; i++) drive(1'b1, 2'(i), 3 * i - 5, -i, 1'b0);
      n = hs_cyc;
      drive(1'b1, 2'b11, 100, 100, 1'b0);
      s_valid = 1'b0;
      wait_done(60, dc);
      chk("t2_done_latency", dc - n, 15);
      chk("t2_writes", wen_cnt, 8);
      idle(2);

      // s_valid held through DRAIN/FLUSH: next batch taken on the done cycle.
      wen_cnt = 0;
      s_valid = 1'b1; s_spikes = 2'b11; s_weights = {DW'(6), DW'(-3)}; s_last = 1'b1;
      wait_done(40, d1);
      s_valid = 1'b0;
      wait_done(40, dc);
      chk("t3_first_write_after_done", last_wen_cyc - d1, 1);
      chk("t3_writes", wen_cnt, 2);
      chk_snap("t3", -3, 6, -3, 6);
      idle(2);

      // Bubbles between beats: only valid beats written, order kept.
      wen_cnt = 0;
      drive(1'b1, 2'b01, 2, -1, 1'b0);
      drive(1'b0, 2'b11, 9,  9, 1'b1);
      drive(1'b1, 2'b11, 3,  5, 1'b0);
      drive(1'b0, 2'b11, 9,  9, 1'b1);
      drive(1'b1, 2'b10, 4,  7, 1'b1);
      n = hs_cyc;
      s_valid = 1'b0;
      wait_done(40, dc);
      chk("t6_done_latency", dc - n, 10);
      chk("t6_writes", wen_cnt, 3);
      chk_snap("t6", 5, 4, 7, 12);
      idle(2);

      // Reset at t=1 of DRAIN, then a clean K=1 batch.
      drive(1'b1, 2'b01, 7, 1, 1'b0);
      drive(1'b1, 2'b11, 2, 3, 1'b1);
      idle(2);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      chk("t4_s_ready", s_ready, 1'b1);
      chk("t4_busy", busy, 1'b0);
      chk("t4_r_en0", row_fifo_0_r_en, 1'b0);
      chk("t4_r_en1", row_fifo_1_r_en, 1'b0);
      chk("t4_in_col_0", in_col_0, 0);
      drive(1'b1, 2'b10, 5, -2, 1'b1);
      n = hs_cyc;
      s_valid = 1'b0;
      wait_done(40, dc);
      chk("t4_done_latency", dc - n, 8);
      chk_snap("t4", 0, 0, 5, -2);

      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
